id_stage_p: RTL and testbench

Parametrised instruction-decode pipeline stage for the 16-bit core: decodes a fetched instruction, reads two register operands, and registers all operands and control fields into an ID/EX pipeline register. Generalises the earlier combinational decode stage with configurable data width, a valid/ready handshake on both sides, load-use hazard stalling, flush, sticky halt and optional write-back bypass. Sits between the fetch stage and execute.

---
 rtl/id_pkg.sv | 138 +++++++++++++
 rtl/id_regfile.sv | 54 +++++
 rtl/id_stage_p.sv | 133 +++++++++++++
 tb/tb_id_stage_p.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared definitions for the decode stage: opcodes, ALU op encodings, ID/EX control bundle.
// The control decoder lives here as a function so execute-side checkers can reuse it.
`timescale 1ns/1ps
package id_pkg;

  localparam int ID_DATA_W = 16;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_PADDSB = 4'h1;
  localparam logic [3:0] OP_SUB    = 4'h2;
  localparam logic [3:0] OP_XOR    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_RED    = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LHB    = 4'hA;
  localparam logic [3:0] OP_LLB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  // Arithmetic ops share their opcode value so decode is a plain cast.
  typedef enum logic [3:0] {
    ALU_ADD    = 4'h0,
    ALU_PADDSB = 4'h1,
    ALU_SUB    = 4'h2,
    ALU_XOR    = 4'h3,
    ALU_SLL    = 4'h4,
    ALU_SRA    = 4'h5,
    ALU_ROR    = 4'h6,
    ALU_RED    = 4'h7,
    ALU_LHB    = 4'h8,
    ALU_LLB    = 4'h9,
    ALU_PASS   = 4'hA
  } alu_op_e;

  typedef struct packed {
    logic       wr_reg_en;
    logic       mem_rd;
    logic       mem_wr;
    logic       mem2reg;
    logic       alu_src;
    logic       saw_br;
    logic       saw_j;
    logic       hlt;
    alu_op_e    alu_op;
    logic [3:0] wr_reg;
    logic [3:0] rd_reg1;
    logic [3:0] rd_reg2;
    logic [3:0] sh_amt;
  } ctrl_t;

  typedef struct packed {
    ctrl_t ctrl;
    logic  rd_en1;
    logic  rd_en2;
  } dec_t;

  // cond: 000 not-equal, 001 equal, 111 always; other codes need flags this core lacks.
  function automatic logic br_taken(input logic [2:0] cond, input logic z);
    logic t;
    t = 1'b0;
    case (cond)
      3'b000:  t = ~z;
      3'b001:  t = z;
      3'b111:  t = 1'b1;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic dec_t decode_ctrl(input logic [15:0] instr, input logic z);
    dec_t       d;
    logic [3:0] op;
    op = instr[15:12];
    d = '0;
    d.ctrl.wr_reg  = instr[11:8];
    d.ctrl.rd_reg1 = instr[7:4];
    d.ctrl.rd_reg2 = instr[3:0];
    d.ctrl.alu_op  = ALU_ADD;
    case (op)
      OP_ADD, OP_PADDSB, OP_SUB, OP_XOR, OP_RED: begin
        d.ctrl.wr_reg_en = 1'b1;
        d.ctrl.alu_op    = alu_op_e'(op);
        d.rd_en1         = 1'b1;
        d.rd_en2         = 1'b1;
      end
      OP_SLL, OP_SRA, OP_ROR: begin
        d.ctrl.wr_reg_en = 1'b1;
        d.ctrl.alu_op    = alu_op_e'(op);
        d.ctrl.alu_src   = 1'b1;
        d.ctrl.sh_amt    = instr[3:0];
        d.rd_en1         = 1'b1;
      end
      OP_LW: begin
        d.ctrl.wr_reg_en = 1'b1;
        d.ctrl.mem_rd    = 1'b1;
        d.ctrl.mem2reg   = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.rd_en1         = 1'b1;
      end
      OP_SW: begin
        // Store data comes from the rd field position.
        d.ctrl.mem_wr  = 1'b1;
        d.ctrl.alu_src = 1'b1;
        d.ctrl.rd_reg2 = instr[11:8];
        d.rd_en1       = 1'b1;
        d.rd_en2       = 1'b1;
      end
      OP_LHB, OP_LLB: begin
        d.ctrl.wr_reg_en = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.ctrl.alu_op    = (op == OP_LHB) ? ALU_LHB : ALU_LLB;
        d.ctrl.rd_reg1   = instr[11:8];
        d.rd_en1         = 1'b1;
      end
      OP_B: begin
        d.ctrl.saw_br = br_taken(instr[11:9], z);
      end
      OP_BR: begin
        d.ctrl.saw_j = br_taken(instr[11:9], z);
        d.rd_en1     = 1'b1;
      end
      OP_PCS: begin
        d.ctrl.wr_reg_en = 1'b1;
        d.ctrl.alu_op    = ALU_PASS;
      end
      default: begin
        d.ctrl.hlt = 1'b1;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// Register file, NREGS x DATA_W, two async read ports and one write port; R0 hardwired to zero.
// Same-cycle write-to-read forwarding only when built with ID_BYPASS_EN.
`timescale 1ns/1ps
module id_regfile
  import id_pkg::*;
#(
  parameter int DATA_W = ID_DATA_W,
  parameter int NREGS  = 16
) (
  input  logic              i_clk,
  input  logic              i_nRst,
  input  logic              wr_en,
  input  logic [3:0]        wr_reg,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic [3:0]        rd_reg1,
  input  logic [3:0]        rd_reg2,
  output logic [DATA_W-1:0] rd_dat1,
  output logic [DATA_W-1:0] rd_dat2
);

  localparam int AW = $clog2(NREGS);

  logic [DATA_W-1:0] mem [NREGS];
  logic              wr_ok;
  logic              rd_ok1;
  logic              rd_ok2;

  // Register indices beyond NREGS read as zero and ignore writes.
  assign wr_ok  = wr_en && (wr_reg != 4'd0) && ({1'b0, wr_reg} < 5'(NREGS));
  assign rd_ok1 = {1'b0, rd_reg1} < 5'(NREGS);
  assign rd_ok2 = {1'b0, rd_reg2} < 5'(NREGS);

  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[wr_reg[AW-1:0]] <= wr_dat;
    end
  end

  always_comb begin
    rd_dat1 = '0;
    rd_dat2 = '0;
    if (rd_ok1) rd_dat1 = mem[rd_reg1[AW-1:0]];
    if (rd_ok2) rd_dat2 = mem[rd_reg2[AW-1:0]];
`ifdef ID_BYPASS_EN
    if (wr_ok && (wr_reg == rd_reg1)) rd_dat1 = wr_dat;
    if (wr_ok && (wr_reg == rd_reg2)) rd_dat2 = wr_dat;
`endif
  end

endmodule

// File: rtl/id_stage_p.sv
// Decode + operand read into the ID/EX register, 1-cycle latency; build option ID_BYPASS_EN.
// Backpressure: ID/EX holds while i_exReady=0; o_ready drops on stall, load-use hazard or sticky halt.
`timescale 1ns/1ps
module id_stage_p
  import id_pkg::*;
#(
  parameter int DATA_W = ID_DATA_W,
  parameter int NREGS  = 16
) (
  input  logic              i_clk,
  input  logic              i_nRst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [15:0]       i_instr,
  input  logic [15:0]       i_pc,
  input  logic              i_Z,
  input  logic              i_flush,
  input  logic              i_exReady,
  input  logic              i_wrEn,
  input  logic [3:0]        i_wrReg,
  input  logic [DATA_W-1:0] i_wrData,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_port0,
  output logic [DATA_W-1:0] o_port1,
  output logic [DATA_W-1:0] o_sext,
  output logic [15:0]       o_instr,
  output logic [15:0]       o_pc,
  output logic [3:0]        o_wrReg,
  output logic [3:0]        o_rdReg1,
  output logic [3:0]        o_rdReg2,
  output logic [3:0]        o_aluOp,
  output logic [3:0]        o_shAmt,
  output logic              o_wrRegEn,
  output logic              o_memRd,
  output logic              o_memWr,
  output logic              o_mem2reg,
  output logic              o_aluSrc,
  output logic              o_sawBr,
  output logic              o_sawJ,
  output logic              o_hlt
);

  dec_t              dec;
  ctrl_t             ex_ctrl;
  logic              ex_vld;
  logic              halted;
  logic [DATA_W-1:0] rd_dat1;
  logic [DATA_W-1:0] rd_dat2;
  logic [DATA_W-1:0] port0_q;
  logic [DATA_W-1:0] port1_q;
  logic [DATA_W-1:0] sext_q;
  logic [15:0]       instr_q;
  logic [15:0]       pc_q;
  logic              advance;
  logic              hazard;
  logic              take;
  logic              load;

  assign dec = decode_ctrl(i_instr, i_Z);

  id_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .i_clk   (i_clk),
    .i_nRst  (i_nRst),
    .wr_en   (i_wrEn),
    .wr_reg  (i_wrReg),
    .wr_dat  (i_wrData),
    .rd_reg1 (dec.ctrl.rd_reg1),
    .rd_reg2 (dec.ctrl.rd_reg2),
    .rd_dat1 (rd_dat1),
    .rd_dat2 (rd_dat2)
  );

  assign advance = i_exReady | ~ex_vld;
  assign hazard  = ex_vld & ex_ctrl.mem_rd & ex_ctrl.wr_reg_en & (ex_ctrl.wr_reg != 4'd0) & i_valid &
                   ((dec.rd_en1 & (dec.ctrl.rd_reg1 == ex_ctrl.wr_reg)) |
                    (dec.rd_en2 & (dec.ctrl.rd_reg2 == ex_ctrl.wr_reg)));
  assign o_ready = advance & ~hazard & ~halted;
  assign take    = i_valid & o_ready & ~i_flush;
  // Flush must empty ID/EX even when execute is stalled.
  assign load    = advance | i_flush;

  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) begin
      ex_vld  <= 1'b0;
      ex_ctrl <= '0;
      port0_q <= '0;
      port1_q <= '0;
      sext_q  <= '0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (load) begin
      ex_vld  <= take;
      ex_ctrl <= take ? dec.ctrl : '0;
      port0_q <= take ? rd_dat1 : '0;
      port1_q <= take ? rd_dat2 : '0;
      sext_q  <= take ? DATA_W'($signed(i_instr[7:0])) : '0;
      instr_q <= take ? i_instr : '0;
      pc_q    <= take ? i_pc : '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) begin
      halted <= 1'b0;
    end else if (take && dec.ctrl.hlt) begin
      halted <= 1'b1;
    end
  end

  assign o_valid   = ex_vld;
  assign o_port0   = port0_q;
  assign o_port1   = port1_q;
  assign o_sext    = sext_q;
  assign o_instr   = instr_q;
  assign o_pc      = pc_q;
  assign o_wrReg   = ex_ctrl.wr_reg;
  assign o_rdReg1  = ex_ctrl.rd_reg1;
  assign o_rdReg2  = ex_ctrl.rd_reg2;
  assign o_aluOp   = ex_ctrl.alu_op;
  assign o_shAmt   = ex_ctrl.sh_amt;
  assign o_wrRegEn = ex_ctrl.wr_reg_en;
  assign o_memRd   = ex_ctrl.mem_rd;
  assign o_memWr   = ex_ctrl.mem_wr;
  assign o_mem2reg = ex_ctrl.mem2reg;
  assign o_aluSrc  = ex_ctrl.alu_src;
  assign o_sawBr   = ex_ctrl.saw_br;
  assign o_sawJ    = ex_ctrl.saw_j;
  assign o_hlt     = ex_ctrl.hlt;

endmodule

// File: tb/tb_id_stage_p.sv
// Directed bench for id_stage_p: reset, decode/operand read, load-use bubble, stall, flush,
// write-back forwarding (expectation follows ID_BYPASS_EN), sign extension, branch decode, halt.
`timescale 1ns/1ps
module tb_id_stage_p;

  localparam int DATA_W = 16;

`ifdef ID_BYPASS_EN
  localparam logic [15:0] BYP_EXP = 16'hBEEF;
`else
  localparam logic [15:0] BYP_EXP = 16'h0000;
`endif

  logic              i_clk = 1'b0;
  logic              i_nRst;
  logic              i_valid;
  logic              o_ready;
  logic [15:0]       i_instr;
  logic [15:0]       i_pc;
  logic              i_Z;
  logic              i_flush;
  logic              i_exReady;
  logic              i_wrEn;
  logic [3:0]        i_wrReg;
  logic [DATA_W-1:0] i_wrData;
  logic              o_valid;
  logic [DATA_W-1:0] o_port0;
  logic [DATA_W-1:0] o_port1;
  logic [DATA_W-1:0] o_sext;
  logic [15:0]       o_instr;
  logic [15:0]       o_pc;
  logic [3:0]        o_wrReg;
  logic [3:0]        o_rdReg1;
  logic [3:0]        o_rdReg2;
  logic [3:0]        o_aluOp;
  logic [3:0]        o_shAmt;
  logic              o_wrRegEn;
  logic              o_memRd;
  logic              o_memWr;
  logic              o_mem2reg;
  logic              o_aluSrc;
  logic              o_sawBr;
  logic              o_sawJ;
  logic              o_hlt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  id_stage_p #(.DATA_W(DATA_W), .NREGS(16)) dut (
    .i_clk     (i_clk),
    .i_nRst    (i_nRst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_instr   (i_instr),
    .i_pc      (i_pc),
    .i_Z       (i_Z),
    .i_flush   (i_flush),
    .i_exReady (i_exReady),
    .i_wrEn    (i_wrEn),
    .i_wrReg   (i_wrReg),
    .i_wrData  (i_wrData),
    .o_valid   (o_valid),
    .o_port0   (o_port0),
    .o_port1   (o_port1),
    .o_sext    (o_sext),
    .o_instr   (o_instr),
    .o_pc      (o_pc),
    .o_wrReg   (o_wrReg),
    .o_rdReg1  (o_rdReg1),
    .o_rdReg2  (o_rdReg2),
    .o_aluOp   (o_aluOp),
    .o_shAmt   (o_shAmt),
    .o_wrRegEn (o_wrRegEn),
    .o_memRd   (o_memRd),
    .o_memWr   (o_memWr),
    .o_mem2reg (o_mem2reg),
    .o_aluSrc  (o_aluSrc),
    .o_sawBr   (o_sawBr),
    .o_sawJ    (o_sawJ),
    .o_hlt     (o_hlt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_nRst = 1'b0; i_valid = 1'b0; i_instr = '0; i_pc = '0; i_Z = 1'b0; i_flush = 1'b0;
    i_exReady = 1'b1; i_wrEn = 1'b0; i_wrReg = '0; i_wrData = '0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_hlt",   32'(o_hlt),   32'd0);
    check("rst_port0", 32'(o_port0), 32'd0);
    check("rst_instr", 32'(o_instr), 32'd0);
    i_nRst = 1'b1;
    #1;
    check("rst_ready", 32'(o_ready), 32'd1);

    // R3 = 0x1234, then ADD R5,R3,R3
    i_wrEn = 1'b1; i_wrReg = 4'd3; i_wrData = 16'h1234;
    cyc();
    i_wrEn = 1'b0; i_valid = 1'b1; i_instr = 16'h0533; i_pc = 16'h0010;
    cyc();
    check("add_valid", 32'(o_valid),   32'd1);
    check("add_port0", 32'(o_port0),   32'h1234);
    check("add_port1", 32'(o_port1),   32'h1234);
    check("add_wrreg", 32'(o_wrReg),   32'd5);
    check("add_pc",    32'(o_pc),      32'h0010);
    check("add_wren",  32'(o_wrRegEn), 32'd1);
    check("add_aluop", 32'(o_aluOp),   32'd0);

    // LW R4,0(R0) then dependent ADD R6,R4,R1
    i_instr = 16'h8400; i_pc = 16'h0012;
    #1;
    check("lw_ready", 32'(o_ready), 32'd1);
    cyc();
    check("lw_memrd",   32'(o_memRd),   32'd1);
    check("lw_mem2reg", 32'(o_mem2reg), 32'd1);
    check("lw_wrreg",   32'(o_wrReg),   32'd4);
    i_instr = 16'h0641; i_pc = 16'h0014;
    #1;
    check("hz_ready", 32'(o_ready), 32'd0);
    cyc();
    check("hz_bubble_valid", 32'(o_valid),   32'd0);
    check("hz_bubble_wren",  32'(o_wrRegEn), 32'd0);
    #1;
    check("hz_ready_again", 32'(o_ready), 32'd1);
    cyc();
    check("hz_add_valid", 32'(o_valid),  32'd1);
    check("hz_add_instr", 32'(o_instr),  32'h0641);
    check("hz_add_rd1",   32'(o_rdReg1), 32'd4);
    check("hz_add_rd2",   32'(o_rdReg2), 32'd1);

    // Execute stalls for 3 cycles
    i_exReady = 1'b0; i_instr = 16'h0722; i_pc = 16'h0016;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_ready", 32'(o_ready), 32'd0);
      cyc();
      check("stall_hold_instr", 32'(o_instr), 32'h0641);
      check("stall_hold_valid", 32'(o_valid), 32'd1);
    end
    i_exReady = 1'b1;
    #1;
    check("stall_release_ready", 32'(o_ready), 32'd1);
    cyc();
    check("stall_next_instr", 32'(o_instr), 32'h0722);
    check("stall_next_wrreg", 32'(o_wrReg), 32'd7);

    // Flush while accepting, then flush while execute is stalled
    i_instr = 16'h0811; i_pc = 16'h0018; i_flush = 1'b1;
    cyc();
    check("flush_valid", 32'(o_valid),   32'd0);
    check("flush_instr", 32'(o_instr),   32'd0);
    check("flush_wren",  32'(o_wrRegEn), 32'd0);
    i_flush = 1'b0;
    cyc();
    check("reload_valid", 32'(o_valid), 32'd1);
    check("reload_wrreg", 32'(o_wrReg), 32'd8);
    i_valid = 1'b0; i_exReady = 1'b0; i_flush = 1'b1;
    cyc();
    check("flush_stalled_valid", 32'(o_valid), 32'd0);
    i_flush = 1'b0; i_exReady = 1'b1;

    // Write R2 and read it in the same cycle: ADD R9,R2,R0
    i_wrEn = 1'b1; i_wrReg = 4'd2; i_wrData = 16'hBEEF;
    i_valid = 1'b1; i_instr = 16'h0920; i_pc = 16'h001A;
    cyc();
    check("byp_port0", 32'(o_port0), 32'(BYP_EXP));
    check("byp_port1", 32'(o_port1), 32'd0);
    i_wrEn = 1'b0;
    cyc();
    check("byp_after_port0", 32'(o_port0), 32'hBEEF);

    // LLB sign extension, negative and positive byte
    i_instr = 16'hB580;
    cyc();
    check("sext_neg",   32'(o_sext),   32'hFF80);
    check("llb_alusrc", 32'(o_aluSrc), 32'd1);
    check("llb_aluop",  32'(o_aluOp),  32'd9);
    i_instr = 16'hB57F;
    cyc();
    check("sext_pos", 32'(o_sext), 32'h007F);

    // Branch-if-equal against the zero flag
    i_instr = 16'hC200; i_Z = 1'b1;
    cyc();
    check("beq_taken", 32'(o_sawBr), 32'd1);
    i_Z = 1'b0;
    cyc();
    check("beq_not_taken", 32'(o_sawBr), 32'd0);

    // HLT: sticky not-ready, ID/EX still drains
    i_instr = 16'hF000;
    cyc();
    check("hlt_flag",  32'(o_hlt),   32'd1);
    check("hlt_valid", 32'(o_valid), 32'd1);
    i_instr = 16'h0533;
    #1;
    check("hlt_ready", 32'(o_ready), 32'd0);
    cyc();
    check("hlt_drained", 32'(o_valid), 32'd0);
    check("hlt_flag_drained", 32'(o_hlt), 32'd0);
    cyc();
    check("hlt_ready_sticky", 32'(o_ready), 32'd0);

    // Reset mid-halt
    i_nRst = 1'b0;
    #1;
    check("rst2_valid", 32'(o_valid), 32'd0);
    check("rst2_hlt",   32'(o_hlt),   32'd0);
    i_nRst = 1'b1;
    #1;
    check("rst2_ready", 32'(o_ready), 32'd1);
    cyc();
    check("rst2_add_valid", 32'(o_valid), 32'd1);
    check("rst2_rf_cleared", 32'(o_port0), 32'd0);

    i_valid = 1'b0;
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
